// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - streams register-file and data-memory contents to a debug host
//
// Purpose:
//   On a start pulse, walks register-file entries 0..REG_COUNT-1 and then
//   data-memory words 0..MEM_WORDS-1 through the CPU's spare read ports.
//   Each word is emitted on a valid/ready port tagged with its source and
//   index. A one-cycle done pulse follows the acceptance of the final word.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start, abort          begin a dump (IDLE only) / cancel an active dump
//   busy, done            activity flag / completion pulse
//   rf_re, rf_raddr       register-file read request
//   rf_rdata              register data, valid the cycle after rf_re
//   mem_re, mem_raddr     data-memory read request
//   mem_rdata             memory data, valid the cycle after mem_re
//   out_valid, out_ready  output handshake
//   out_data, out_src     dumped word and source (0 = regs, 1 = memory)
//   out_index, out_last   zero-extended index and final-word marker

module state_dump_unit #(
    parameter int DATA_W    = 19,
    parameter int REG_COUNT = 16,
    parameter int MEM_WORDS = 256,
    parameter int RA_W      = $clog2(REG_COUNT),
    parameter int MA_W      = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rf_re,
    output logic [RA_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_re,
    output logic [MA_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic [MA_W:0]     out_index,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam int IX_W = MA_W + 1;
    localparam logic [IX_W-1:0] REG_LAST = IX_W'(REG_COUNT - 1);
    localparam logic [IX_W-1:0] MEM_LAST = IX_W'(MEM_WORDS - 1);

    state_t          state;
    logic [IX_W-1:0] idx;
    logic            src;

    // Position of the word after the current one; the register sweep rolls
    // over into memory index 0.
    logic [IX_W-1:0] next_idx;
    logic            next_src;

    always_comb begin
        next_idx = idx + IX_W'(1);
        next_src = src;
        if (!src && idx == REG_LAST) begin
            next_idx = '0;
            next_src = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            src       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_re     <= 1'b0;
            rf_raddr  <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            // Read enables and done are single-cycle; they are raised only on
            // the transition into REQ / DONE respectively.
            rf_re  <= 1'b0;
            mem_re <= 1'b0;
            done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        src       <= 1'b0;
                        rf_re     <= 1'b1;
                        rf_raddr  <= '0;
                        mem_raddr <= '0;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        out_data  <= src ? mem_rdata : rf_rdata;
                        out_src   <= src;
                        out_index <= idx;
                        out_last  <= src && (idx == MEM_LAST);
                        out_valid <= 1'b1;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    // Abort wins over a same-cycle handshake: the word on the
                    // port is treated as never delivered.
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx       <= next_idx;
                            src       <= next_src;
                            rf_re     <= !next_src;
                            mem_re    <= next_src;
                            rf_raddr  <= next_idx[RA_W-1:0];
                            mem_raddr <= next_idx[MA_W-1:0];
                            state     <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
